// File: rtl/analyzer_pkg.sv
// Shared constants for the analyzer read bridge: FSM states, response codes,
// the legal read window and the error word.
package analyzer_pkg;

   localparam logic [0:0]  ST_RD_IDLE  = 1'b0;
   localparam logic [0:0]  ST_RD_DATA  = 1'b1;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   localparam logic [31:0] WIN_LO      = 32'h0100_0000;
   localparam logic [31:0] WIN_HI      = 32'h01FF_FFFF;
   localparam logic [31:0] ERR_WORD    = 32'hFFFF_FFFF;

   // Reserved burst encodings (2'b10, 2'b11) and out-of-window addresses are errors.
   function automatic logic burst_is_err(input logic [31:0] addr, input logic [1:0] burst);
      return burst[1] || (addr < WIN_LO) || (addr > WIN_HI);
   endfunction

endpackage

// File: rtl/analyzer_rd_fifo.sv
// Synchronous prefetch FIFO, DEPTH x 32, with occupancy count and a clear input.
// DEPTH must be a power of two and at least 2.
module analyzer_rd_fifo #(
   parameter int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [31:0]      wdata,
   input  logic             pop,
   output logic [31:0]      rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [31:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == DEPTH_C);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign rdata  = r_mem[r_rd_ptr];
   assign count  = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/analyzer_rd_bridge.sv
// Read-only slave bridge serving bursts from a prefetched sample store.
// Optional stall timeout is enabled by defining ANALYZER_RD_TIMEOUT_EN.
import analyzer_pkg::*;

module analyzer_rd_bridge #(
   parameter int ID_W        = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 1024,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             src_ready,
   output logic             src_valid,
   input  logic [31:0]      src_data,
   input  logic [ID_W-1:0]  RD_ADDR_ID,
   input  logic [31:0]      RD_ADDR_ADDR,
   input  logic [7:0]       RD_ADDR_LEN,
   input  logic [1:0]       RD_ADDR_BURST,
   input  logic             RD_ADDR_VALID,
   output logic             RD_ADDR_READY,
   output logic [ID_W-1:0]  RD_BACK_ID,
   output logic [31:0]      RD_BACK_DATA,
   output logic [1:0]       RD_BACK_RESP,
   output logic             RD_BACK_LAST,
   output logic             RD_BACK_VALID,
   input  logic             RD_DATA_READY,
   output logic [0:0]       o_dbg_state,
   output logic [CNT_W-1:0] o_dbg_fifo_count
);

   // Handshake: a transfer happens on a rising edge where VALID && READY; a
   // source holding VALID keeps its payload stable until that edge.

   logic [0:0]      r_state;
   logic [ID_W-1:0] r_id;
   logic [31:0]     r_addr;
   logic [7:0]      r_len;
   logic [1:0]      r_burst;
   logic [7:0]      r_beat;
   logic            r_inflight;

   logic [31:0]      w_fifo_head;
   logic [CNT_W-1:0] w_fifo_count;
   logic             w_fifo_empty;
   logic             w_fifo_full;
   logic             w_push;
   logic             w_pop;
   logic             w_in_data;
   logic             w_err;
   logic             w_to_beat;
   logic             w_bad_beat;
   logic             w_valid;
   logic             w_last;
   logic             w_rd_hs;

   assign w_in_data = (r_state == ST_RD_DATA);
   assign w_err     = burst_is_err(r_addr, r_burst);

   // Prefetch runs regardless of the FSM; the in-flight word reserves a slot.
   assign src_valid = !rst && src_ready && !flush &&
                      ((int'(w_fifo_count) + int'(r_inflight)) < FIFO_DEPTH);
   assign w_push    = r_inflight && !flush;

   analyzer_rd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (w_push),
      .wdata (src_data),
      .pop   (w_pop),
      .rdata (w_fifo_head),
      .count (w_fifo_count),
      .empty (w_fifo_empty),
      .full  (w_fifo_full)
   );

`ifdef ANALYZER_RD_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

   logic [TO_W-1:0] r_stall_cnt;

   // Saturates at the limit so a pending timeout beat stays stable until taken.
   assign w_to_beat = w_in_data && !w_err && (r_stall_cnt == TO_LIMIT);

   always_ff @(posedge clk) begin
      if (rst || !w_in_data || w_err) begin
         r_stall_cnt <= '0;
      end else if (w_rd_hs) begin
         r_stall_cnt <= '0;
      end else if (w_to_beat) begin
         r_stall_cnt <= r_stall_cnt;
      end else if (w_push) begin
         r_stall_cnt <= '0;
      end else if (w_fifo_empty) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end
`else
   assign w_to_beat = 1'b0;
`endif

   assign w_bad_beat = w_err || w_to_beat;
   assign w_valid    = !rst && w_in_data && (w_bad_beat || !w_fifo_empty);
   assign w_last     = w_valid && (r_beat == r_len);
   assign w_rd_hs    = w_valid && RD_DATA_READY;
   assign w_pop      = w_rd_hs && !w_bad_beat;

   assign RD_ADDR_READY = !rst && (r_state == ST_RD_IDLE);
   assign RD_BACK_VALID = w_valid;
   assign RD_BACK_LAST  = w_last;
   assign RD_BACK_ID    = rst ? '0 : r_id;
   assign RD_BACK_DATA  = rst ? '0 : (w_bad_beat ? ERR_WORD : w_fifo_head);
   assign RD_BACK_RESP  = (rst || !w_bad_beat) ? RESP_OKAY : RESP_SLVERR;

   assign o_dbg_state      = r_state;
   assign o_dbg_fifo_count = w_fifo_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= src_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RD_IDLE;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_burst <= '0;
         r_beat  <= '0;
      end else begin
         case (r_state)
            ST_RD_IDLE: begin
               r_beat <= '0;
               if (RD_ADDR_VALID) begin
                  r_id    <= RD_ADDR_ID;
                  r_addr  <= RD_ADDR_ADDR;
                  r_len   <= RD_ADDR_LEN;
                  r_burst <= RD_ADDR_BURST;
                  r_state <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (w_rd_hs) begin
                  if (w_last) begin
                     r_beat  <= '0;
                     r_state <= ST_RD_IDLE;
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            default: r_state <= ST_RD_IDLE;
         endcase
      end
   end

   logic w_unused;
   assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_analyzer_rd_bridge.sv
// Directed self-checking bench for analyzer_rd_bridge with a modelled sample store.
// Timeout expectations follow ANALYZER_RD_TIMEOUT_EN.
module tb_analyzer_rd_bridge;

   localparam int ID_W        = 4;
   localparam int FIFO_DEPTH  = 4;
   localparam int TIMEOUT_CYC = 16;
   localparam int CNT_W       = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             src_ready = 1'b0;
   logic             src_valid;
   logic [31:0]      src_data = 32'h0;
   logic [ID_W-1:0]  RD_ADDR_ID = '0;
   logic [31:0]      RD_ADDR_ADDR = '0;
   logic [7:0]       RD_ADDR_LEN = '0;
   logic [1:0]       RD_ADDR_BURST = '0;
   logic             RD_ADDR_VALID = 1'b0;
   logic             RD_ADDR_READY;
   logic [ID_W-1:0]  RD_BACK_ID;
   logic [31:0]      RD_BACK_DATA;
   logic [1:0]       RD_BACK_RESP;
   logic             RD_BACK_LAST;
   logic             RD_BACK_VALID;
   logic             RD_DATA_READY = 1'b0;
   logic [0:0]       o_dbg_state;
   logic [CNT_W-1:0] o_dbg_fifo_count;

   int n_checks = 0;
   int n_fail   = 0;

   analyzer_rd_bridge #(
      .ID_W        (ID_W),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .src_ready        (src_ready),
      .src_valid        (src_valid),
      .src_data         (src_data),
      .RD_ADDR_ID       (RD_ADDR_ID),
      .RD_ADDR_ADDR     (RD_ADDR_ADDR),
      .RD_ADDR_LEN      (RD_ADDR_LEN),
      .RD_ADDR_BURST    (RD_ADDR_BURST),
      .RD_ADDR_VALID    (RD_ADDR_VALID),
      .RD_ADDR_READY    (RD_ADDR_READY),
      .RD_BACK_ID       (RD_BACK_ID),
      .RD_BACK_DATA     (RD_BACK_DATA),
      .RD_BACK_RESP     (RD_BACK_RESP),
      .RD_BACK_LAST     (RD_BACK_LAST),
      .RD_BACK_VALID    (RD_BACK_VALID),
      .RD_DATA_READY    (RD_DATA_READY),
      .o_dbg_state      (o_dbg_state),
      .o_dbg_fifo_count (o_dbg_fifo_count)
   );

   // ---------------- clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- sample store model: word appears 1 cycle after the pop strobe
   logic [31:0] store_q[$];
   int          pop_cnt = 0;
   logic        store_take;

   always @(posedge clk) begin
      store_take = src_valid;
      #1;
      if (store_take) begin
         if (store_q.size() > 0) src_data = store_q.pop_front();
         else                    src_data = 32'hDEAD_DEAD;
         pop_cnt++;
      end
      src_ready = (store_q.size() != 0);
   end

   // ---------------- driver tasks (called at negedge)
   logic [31:0]     got_data[$];
   logic [1:0]      got_resp[$];
   logic            got_last[$];
   logic [ID_W-1:0] got_id[$];

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_addr(input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
      int cyc = 0;
      RD_ADDR_ID    = id;
      RD_ADDR_ADDR  = addr;
      RD_ADDR_LEN   = len;
      RD_ADDR_BURST = burst;
      RD_ADDR_VALID = 1'b1;
      #1;
      while (!RD_ADDR_READY && cyc < 50) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      n_checks++;
      if (cyc >= 50) begin
         n_fail++;
         $display("FAIL addr_ready_timeout: ready=%0b after %0d cycles, required 1", RD_ADDR_READY, cyc);
      end
      @(negedge clk);
      RD_ADDR_VALID = 1'b0;
   endtask

   task automatic collect(input int n, input int budget);
      int cyc = 0;
      got_data.delete();
      got_resp.delete();
      got_last.delete();
      got_id.delete();
      RD_DATA_READY = 1'b1;
      #1;
      while (got_data.size() < n && cyc < budget) begin
         if (RD_BACK_VALID) begin
            got_data.push_back(RD_BACK_DATA);
            got_resp.push_back(RD_BACK_RESP);
            got_last.push_back(RD_BACK_LAST);
            got_id.push_back(RD_BACK_ID);
         end
         @(negedge clk);
         #1;
         cyc++;
      end
      RD_DATA_READY = 1'b0;
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      store_q.push_back(32'h11);
      store_q.push_back(32'h22);
      store_q.push_back(32'h33);
      store_q.push_back(32'h44);
      wait_cyc(3);
      #1;
      n_checks++; if (src_valid !== 1'b0) begin n_fail++; $display("FAIL rst_src_valid: got %0b required 0", src_valid); end
      n_checks++; if (RD_ADDR_READY !== 1'b0) begin n_fail++; $display("FAIL rst_addr_ready: got %0b required 0", RD_ADDR_READY); end
      n_checks++; if (RD_BACK_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_back_valid: got %0b required 0", RD_BACK_VALID); end
      n_checks++; if (RD_BACK_RESP !== 2'b00) begin n_fail++; $display("FAIL rst_resp: got %b required 00", RD_BACK_RESP); end
      n_checks++; if (o_dbg_fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_fifo_count: got %0d required 0", o_dbg_fifo_count); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      n_checks++; if (RD_ADDR_READY !== 1'b1) begin n_fail++; $display("FAIL post_rst_addr_ready: got %0b required 1", RD_ADDR_READY); end
      n_checks++; if (o_dbg_state !== 1'b0) begin n_fail++; $display("FAIL post_rst_state: got %0d required 0", o_dbg_state); end
   endtask

   task automatic test_good_burst();
      logic [31:0] exp_d[4];
      exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
      wait_cyc(8);
      n_checks++; if (o_dbg_fifo_count !== 3'd4) begin n_fail++; $display("FAIL good_prefill_count: got %0d required 4", o_dbg_fifo_count); end
      n_checks++; if (pop_cnt !== 4) begin n_fail++; $display("FAIL good_prefill_pops: got %0d required 4", pop_cnt); end
      send_addr(4'h5, 32'h0100_0000, 8'd3, 2'b01);
      collect(4, 40);
      n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL good_beats: got %0d required 4", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         n_checks++; if (got_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL good_data[%0d]: got %h required %h", i, got_data[i], exp_d[i]); end
         n_checks++; if (got_resp[i] !== 2'b00) begin n_fail++; $display("FAIL good_resp[%0d]: got %b required 00", i, got_resp[i]); end
         n_checks++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL good_last[%0d]: got %0b required %0b", i, got_last[i], (i == 3)); end
         n_checks++; if (got_id[i] !== 4'h5) begin n_fail++; $display("FAIL good_id[%0d]: got %h required 5", i, got_id[i]); end
      end
      n_checks++; if (RD_ADDR_READY !== 1'b1) begin n_fail++; $display("FAIL good_back_idle: got %0b required 1", RD_ADDR_READY); end
      n_checks++; if (o_dbg_fifo_count !== 3'd0) begin n_fail++; $display("FAIL good_drained: got %0d required 0", o_dbg_fifo_count); end
   endtask

   task automatic test_err_burst();
      int pops0;
      logic [31:0] exp_d[4];
      exp_d = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
      for (int i = 0; i < 4; i++) store_q.push_back(exp_d[i]);
      wait_cyc(8);
      pops0 = pop_cnt;
      send_addr(4'h3, 32'h0000_0010, 8'd1, 2'b01);
      collect(2, 20);
      n_checks++; if (got_data.size() !== 2) begin n_fail++; $display("FAIL err_beats: got %0d required 2", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 2; i++) begin
         n_checks++; if (got_data[i] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL err_data[%0d]: got %h required ffffffff", i, got_data[i]); end
         n_checks++; if (got_resp[i] !== 2'b10) begin n_fail++; $display("FAIL err_resp[%0d]: got %b required 10", i, got_resp[i]); end
         n_checks++; if (got_last[i] !== (i == 1)) begin n_fail++; $display("FAIL err_last[%0d]: got %0b required %0b", i, got_last[i], (i == 1)); end
      end
      n_checks++; if (pop_cnt !== pops0) begin n_fail++; $display("FAIL err_no_pop: got %0d pops required %0d", pop_cnt, pops0); end
      n_checks++; if (o_dbg_fifo_count !== 3'd4) begin n_fail++; $display("FAIL err_fifo_kept: got %0d required 4", o_dbg_fifo_count); end
      // reserved burst type inside the window
      send_addr(4'h2, 32'h0100_0040, 8'd0, 2'b10);
      collect(1, 20);
      n_checks++; if (got_data.size() !== 1 || got_resp[0] !== 2'b10 || got_data[0] !== 32'hFFFF_FFFF || got_last[0] !== 1'b1)
         begin n_fail++; $display("FAIL err_burst_type: beats %0d, required one SLVERR beat", got_data.size()); end
      // first address past the window
      send_addr(4'h2, 32'h0200_0000, 8'd0, 2'b01);
      collect(1, 20);
      n_checks++; if (got_data.size() !== 1 || got_resp[0] !== 2'b10)
         begin n_fail++; $display("FAIL err_above_window: beats %0d, required one SLVERR beat", got_data.size()); end
      // last word inside the window is good and drains the kept words
      send_addr(4'h9, 32'h01FF_FFFC, 8'd3, 2'b00);
      collect(4, 40);
      n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL win_top_beats: got %0d required 4", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         n_checks++; if (got_data[i] !== exp_d[i] || got_resp[i] !== 2'b00)
            begin n_fail++; $display("FAIL win_top_data[%0d]: got %h/%b required %h/00", i, got_data[i], got_resp[i], exp_d[i]); end
      end
   endtask

   task automatic test_backpressure();
      int pops0;
      logic [31:0] exp_d[6];
      exp_d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
      pops0 = pop_cnt;
      RD_DATA_READY = 1'b0;
      for (int i = 0; i < 6; i++) store_q.push_back(exp_d[i]);
      wait_cyc(12);
      #1;
      n_checks++; if (pop_cnt - pops0 !== 4) begin n_fail++; $display("FAIL bp_pops: got %0d required 4", pop_cnt - pops0); end
      n_checks++; if (src_valid !== 1'b0) begin n_fail++; $display("FAIL bp_src_valid: got %0b required 0", src_valid); end
      n_checks++; if (o_dbg_fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d required 4", o_dbg_fifo_count); end
      send_addr(4'h7, 32'h0100_0100, 8'd5, 2'b01);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (RD_BACK_VALID !== 1'b1 || RD_BACK_DATA !== 32'hB0)
            begin n_fail++; $display("FAIL bp_hold[%0d]: got %0b/%h required 1/000000b0", i, RD_BACK_VALID, RD_BACK_DATA); end
         @(negedge clk);
      end
      collect(6, 60);
      n_checks++; if (got_data.size() !== 6) begin n_fail++; $display("FAIL bp_beats: got %0d required 6", got_data.size()); end
      for (int i = 0; i < got_data.size() && i < 6; i++) begin
         n_checks++; if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 5))
            begin n_fail++; $display("FAIL bp_data[%0d]: got %h last %0b required %h last %0b", i, got_data[i], got_last[i], exp_d[i], (i == 5)); end
      end
   endtask

   task automatic test_flush();
      int cyc = 0;
      store_q.push_back(32'h51);
      store_q.push_back(32'h52);
      store_q.push_back(32'h53);
      wait_cyc(8);
      n_checks++; if (o_dbg_fifo_count !== 3'd3) begin n_fail++; $display("FAIL flush_fill: got %0d required 3", o_dbg_fifo_count); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_checks++; if (o_dbg_fifo_count !== 3'd0) begin n_fail++; $display("FAIL flush_empty: got %0d required 0", o_dbg_fifo_count); end
      store_q.push_back(32'hAA);
      wait_cyc(4);
      send_addr(4'h1, 32'h0100_0000, 8'd0, 2'b01);
      collect(1, 20);
      n_checks++; if (got_data.size() !== 1 || got_data[0] !== 32'hAA)
         begin n_fail++; $display("FAIL flush_first_beat: beats %0d data %h required 000000aa", got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0); end
      // word in flight during the flush cycle is dropped
      store_q.push_back(32'h61);
      #1;
      while (!src_valid && cyc < 10) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_cyc(3);
      n_checks++; if (o_dbg_fifo_count !== 3'd0 || store_q.size() !== 0)
         begin n_fail++; $display("FAIL flush_inflight: count %0d store %0d required 0/0", o_dbg_fifo_count, store_q.size()); end
   endtask

   task automatic test_timeout();
      send_addr(4'h6, 32'h0100_0000, 8'd0, 2'b01);
      for (int i = 0; i < TIMEOUT_CYC; i++) begin
         #1;
         n_checks++; if (RD_BACK_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d]: got %0b required 0", i, RD_BACK_VALID); end
         @(negedge clk);
      end
      #1;
`ifdef ANALYZER_RD_TIMEOUT_EN
      n_checks++; if (RD_BACK_VALID !== 1'b1 || RD_BACK_DATA !== 32'hFFFF_FFFF || RD_BACK_RESP !== 2'b10 || RD_BACK_LAST !== 1'b1)
         begin n_fail++; $display("FAIL timeout_beat: got v%0b %h %b l%0b required v1 ffffffff 10 l1", RD_BACK_VALID, RD_BACK_DATA, RD_BACK_RESP, RD_BACK_LAST); end
      collect(1, 5);
`else
      n_checks++; if (RD_BACK_VALID !== 1'b0) begin n_fail++; $display("FAIL no_timeout_valid: got %0b required 0", RD_BACK_VALID); end
      store_q.push_back(32'h77);
      collect(1, 20);
      n_checks++; if (got_data.size() !== 1 || got_data[0] !== 32'h77 || got_resp[0] !== 2'b00)
         begin n_fail++; $display("FAIL stall_resume: beats %0d, required one OKAY beat 00000077", got_data.size()); end
`endif
      #1;
      n_checks++; if (RD_ADDR_READY !== 1'b1) begin n_fail++; $display("FAIL stall_back_idle: got %0b required 1", RD_ADDR_READY); end
   endtask

   task automatic test_rst_mid_burst();
      store_q.push_back(32'hC1);
      store_q.push_back(32'hC2);
      store_q.push_back(32'hC3);
      store_q.push_back(32'hC4);
      wait_cyc(8);
      send_addr(4'h4, 32'h0100_0000, 8'd3, 2'b01);
      RD_DATA_READY = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (RD_BACK_VALID !== 1'b1 || RD_BACK_DATA !== 32'hC2 || RD_BACK_LAST !== 1'b0)
         begin n_fail++; $display("FAIL rstmid_beat2: got v%0b %h l%0b required v1 000000c2 l0", RD_BACK_VALID, RD_BACK_DATA, RD_BACK_LAST); end
      rst = 1'b1;
      #1;
      n_checks++; if (RD_BACK_VALID !== 1'b0 || RD_BACK_LAST !== 1'b0 || RD_ADDR_READY !== 1'b0 || RD_BACK_DATA !== 32'h0)
         begin n_fail++; $display("FAIL rstmid_outputs: got v%0b l%0b ar%0b %h required all 0", RD_BACK_VALID, RD_BACK_LAST, RD_ADDR_READY, RD_BACK_DATA); end
      @(negedge clk);
      rst = 1'b0;
      RD_DATA_READY = 1'b0;
      #1;
      n_checks++; if (RD_ADDR_READY !== 1'b1) begin n_fail++; $display("FAIL rstmid_addr_ready: got %0b required 1", RD_ADDR_READY); end
      n_checks++; if (RD_BACK_LAST !== 1'b0 || RD_BACK_VALID !== 1'b0)
         begin n_fail++; $display("FAIL rstmid_no_last: got v%0b l%0b required 0/0", RD_BACK_VALID, RD_BACK_LAST); end
      n_checks++; if (o_dbg_fifo_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_fifo: got %0d required 0", o_dbg_fifo_count); end
   endtask

   // ---------------- sequence and report
   initial begin
      test_reset();
      test_good_burst();
      test_err_burst();
      test_backpressure();
      test_flush();
      test_timeout();
      test_rst_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/analyzer_rd_bridge.md
ANALYZER_RD_BRIDGE -- requirements
Module: analyzer_rd_bridge

Interface
REQ-001 Parameters SHALL be: ID_W, default 4, width of the read ID; FIFO_DEPTH, default 4, prefetch depth (power of 2); TIMEOUT_CYC, default 1024, stall limit in cycles.
REQ-002 clk  in  1  single clock; sample store read side and bus side both run on it.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 flush  in  1  one-cycle pulse on capture restart; discards buffered words.
REQ-005 src_ready  in  1  sample store holds at least one unread word.
REQ-006 src_valid  out  1  pop strobe to the sample store.
REQ-007 src_data  in  32  store word, valid exactly 1 cycle after src_valid.
REQ-008 RD_ADDR_ID/ADDR/LEN/BURST/VALID  in  ID_W/32/8/2/1  and RD_ADDR_READY out 1  slave read-address channel.
REQ-009 RD_BACK_ID/DATA/RESP/LAST/VALID  out  ID_W/32/2/1/1  and RD_DATA_READY in 1  slave read-data channel.

Function
REQ-010 FSM SHALL have states ST_RD_IDLE and ST_RD_DATA; RD_ADDR_READY = ~rst && ST_RD_IDLE.
REQ-011 Address handshake SHALL latch ID, ADDR, LEN, BURST and enter ST_RD_DATA the next cycle.
REQ-012 Burst SHALL be error-flagged if BURST is 2'b10/2'b11 or ADDR is outside 0x0100_0000-0x01FF_FFFF.
REQ-013 Error burst: RD_DATA_VALID=1 every cycle, DATA=0xFFFF_FFFF, RESP=2'b10, no FIFO pop.
REQ-014 Good burst: RD_DATA_VALID = FIFO non-empty; DATA = FIFO head; RESP=2'b00; FIFO pops on handshake.
REQ-015 Beat counter SHALL clear in ST_RD_IDLE and increment per data handshake; RD_DATA_LAST = VALID && count==LEN.
REQ-016 Handshake with LAST SHALL return to ST_RD_IDLE the next cycle; burst of LEN+1 beats.
REQ-017 RD_BACK_ID SHALL equal latched ID throughout the burst.
REQ-018 src_valid SHALL assert when src_ready && ~flush && (fifo_count + inflight) < FIFO_DEPTH, independent of FSM state (prefetch).
REQ-019 Word arriving 1 cycle after src_valid SHALL be written to FIFO; simultaneous push and pop SHALL keep count unchanged.
REQ-020 FIFO SHALL never overflow; full stops src_valid; empty holds RD_DATA_VALID low (stall, no error).
REQ-021 flush SHALL empty FIFO and drop a word in flight that cycle; an open burst SHALL remain in ST_RD_DATA and wait.
REQ-022 RD_DATA and RD_DATA_VALID SHALL hold stable while VALID && ~READY.

Reset
REQ-023 On rst: FSM=ST_RD_IDLE, FIFO empty, in-flight flag 0, counters 0, latched fields 0.
REQ-024 During rst all outputs SHALL be 0 (RD_ADDR_READY 0, src_valid 0, RESP 2'b00).
REQ-025 rst mid-burst SHALL abort the burst without LAST; word returning the cycle after rst SHALL be dropped.

Configuration
REQ-026 Macro ANALYZER_RD_TIMEOUT_EN defined: stall counter counts ST_RD_DATA cycles with FIFO empty on a good burst; at TIMEOUT_CYC it SHALL emit one beat DATA=0xFFFF_FFFF, RESP=2'b10, counter clears per beat and on any push.
REQ-027 Macro undefined: no counter; good-burst stalls wait indefinitely.

Structure
REQ-028 Package analyzer_pkg SHALL hold the FSM state enum, RESP codes (OKAY 2'b00, SLVERR 2'b10), window bounds, error word 0xFFFF_FFFF.
REQ-029 Sub-module analyzer_rd_fifo (synchronous, FIFO_DEPTH x 32, count output) SHALL hold the prefetch buffer.

Verification
REQ-030 Store preloaded 0x11,0x22,0x33,0x44; read ADDR=0x0100_0000 LEN=3 BURST=01 -> 4 beats in order, RESP 00, LAST on beat 4 only.
REQ-031 ADDR=0x0000_0010 LEN=1 -> 2 beats 0xFFFF_FFFF, RESP 10, src_valid pops none for the burst.
REQ-032 src_ready held 1, RD_DATA_READY 0 -> exactly FIFO_DEPTH pops, then src_valid 0; no word lost.
REQ-033 Burst open, store empty, TIMEOUT_CYC=16, macro on -> error beat at cycle 16; macro off -> VALID stays 0.
REQ-034 Buffer 3 words, pulse flush, then store supplies 0xAA -> first beat returned is 0xAA.
REQ-035 rst asserted on beat 2 of LEN=3 burst -> next cycle RD_ADDR_READY 1, no LAST, FIFO count 0.
